// File: rtl/if_pc_ctrl.sv
// if_pc_ctrl: next-PC sequencer for the instruction-fetch stage.
//
// Owns the fetch PC register and drives the select and the legs of an external
// 32-bit 2:1 next-PC mux. Leg a is PC+4 and leg b is the redirect target. It
// also sequences hazard stalls and branch/jump redirects. A redirect that
// arrives while fetch is held is buffered, then replayed when the hold releases.
//
// Optional feature macro: IF_PC_ALIGN_CHECK_EN
//   When defined, applied or latched targets have bits [1:0] cleared, and
//   misalign_o pulses for one cycle after a misaligned redirect.
//
// Ports:
//   clk             single clock, rising edge
//   rst_n           synchronous active-low reset
//   stall_i         hazard-unit hold; PC must not advance
//   redir_valid_i   branch/jump taken this cycle
//   redir_target_i  redirect target address
//   npc_o           pc_o + 4 (mux leg a)
//   tgt_o           selected redirect target (mux leg b)
//   pc_sel_o        mux select, 1 = take tgt_o
//   pc_next_i       mux output, registered on advance
//   pc_o            current fetch PC (registered)
//   fetch_valid_o   pc_o is a valid fetch this cycle (registered)
//   flush_o         kill IF/ID contents
//   misalign_o      misaligned target seen (IF_PC_ALIGN_CHECK_EN only)

module if_pc_ctrl #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redir_valid_i,
  input  logic [PC_W-1:0] redir_target_i,
  output logic [PC_W-1:0] npc_o,
  output logic [PC_W-1:0] tgt_o,
  output logic            pc_sel_o,
  input  logic [PC_W-1:0] pc_next_i,
  output logic [PC_W-1:0] pc_o,
  output logic            fetch_valid_o,
  output logic            flush_o
`ifdef IF_PC_ALIGN_CHECK_EN
  ,
  output logic            misalign_o
`endif
);

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHold,
    StPend
  } state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic [PC_W-1:0] r_pc;
  logic            r_fetch_valid;
  logic [PC_W-1:0] r_pend_tgt;

  logic            w_pc_en;
  logic            w_pend_latch;
  logic            w_pc_sel;
  logic            w_flush;
  logic [PC_W-1:0] w_tgt;
  logic [PC_W-1:0] w_redir_tgt;

`ifdef IF_PC_ALIGN_CHECK_EN
  logic r_misalign;
  logic w_misaligned;
  logic w_mis_evt;

  assign w_misaligned = |redir_target_i[1:0];
  assign w_redir_tgt  = {redir_target_i[PC_W-1:2], 2'b00};
`else
  assign w_redir_tgt  = redir_target_i;
`endif

  always_comb begin
    w_state_d    = r_state;
    w_pc_en      = 1'b0;
    w_pend_latch = 1'b0;
    w_pc_sel     = 1'b0;
    w_flush      = 1'b0;
    w_tgt        = redir_target_i;
`ifdef IF_PC_ALIGN_CHECK_EN
    w_mis_evt    = 1'b0;
`endif
    case (r_state)
      StBoot: begin
        w_state_d = StRun;
      end
      StRun: begin
        // The branch resolves in EX regardless of the IF hold, so it wins.
        if (redir_valid_i) begin
          w_pc_sel = 1'b1;
          w_flush  = 1'b1;
          w_tgt    = w_redir_tgt;
          w_pc_en  = 1'b1;
`ifdef IF_PC_ALIGN_CHECK_EN
          w_mis_evt = w_misaligned;
`endif
        end else if (stall_i) begin
          w_state_d = StHold;
        end else begin
          w_pc_en = 1'b1;
        end
      end
      StHold: begin
        if (redir_valid_i && stall_i) begin
          // Cannot move the PC yet: buffer the target and flush now.
          w_pend_latch = 1'b1;
          w_flush      = 1'b1;
          w_tgt        = w_redir_tgt;
          w_state_d    = StPend;
`ifdef IF_PC_ALIGN_CHECK_EN
          w_mis_evt    = w_misaligned;
`endif
        end else if (redir_valid_i) begin
          w_pc_sel  = 1'b1;
          w_flush   = 1'b1;
          w_tgt     = w_redir_tgt;
          w_pc_en   = 1'b1;
          w_state_d = StRun;
`ifdef IF_PC_ALIGN_CHECK_EN
          w_mis_evt = w_misaligned;
`endif
        end else if (!stall_i) begin
          w_pc_en   = 1'b1;
          w_state_d = StRun;
        end
      end
      StPend: begin
        // Later redirects are ignored; the buffered (older) one wins.
        w_tgt = r_pend_tgt;
        if (!stall_i) begin
          w_pc_sel  = 1'b1;
          w_pc_en   = 1'b1;
          w_state_d = StRun;
        end
      end
      default: begin
        w_state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= StBoot;
      r_pc          <= RESET_PC;
      r_fetch_valid <= 1'b0;
      r_pend_tgt    <= '0;
`ifdef IF_PC_ALIGN_CHECK_EN
      r_misalign    <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_d;
      r_fetch_valid <= (w_state_d == StRun) || (w_state_d == StHold);
      if (w_pc_en) begin
        r_pc <= pc_next_i;
      end
      if (w_pend_latch) begin
        r_pend_tgt <= w_redir_tgt;
      end
`ifdef IF_PC_ALIGN_CHECK_EN
      r_misalign    <= w_mis_evt;
`endif
    end
  end

  assign npc_o         = r_pc + {{(PC_W-3){1'b0}}, 3'd4};
  assign tgt_o         = w_tgt;
  assign pc_sel_o      = w_pc_sel;
  assign flush_o       = w_flush;
  assign pc_o          = r_pc;
  assign fetch_valid_o = r_fetch_valid;
`ifdef IF_PC_ALIGN_CHECK_EN
  assign misalign_o    = r_misalign;
`endif

endmodule

// File: doc/if_pc_ctrl.md
# if_pc_ctrl

Next-PC sequencer for the instruction-fetch stage. It owns the PC register and drives the 32-bit 2:1 next-PC mux: leg a carries PC+4, leg b carries the redirect target, and sel chooses between them. It also sequences pipeline stalls and branch/jump redirects. A redirect that arrives while fetch is held is buffered and replayed when the hold releases.

## Interface
Parameters:
- PC_W, 32, PC width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports (reset is synchronous and active-low):
- clk, input, 1, single clock; all state updates on rising edge.
- rst_n, input, 1, synchronous active-low reset.
- stall_i, input, 1, hazard-unit hold; PC must not advance.
- redir_valid_i, input, 1, branch/jump taken this cycle (from EX).
- redir_target_i, input, PC_W, redirect target address.
- npc_o, output, PC_W, pc_o + 4; drives mux leg a.
- tgt_o, output, PC_W, selected redirect target; drives mux leg b.
- pc_sel_o, output, 1, mux select; 1 = take tgt_o.
- pc_next_i, input, PC_W, mux output y, returned for registering.
- pc_o, output, PC_W, current fetch PC (registered).
- fetch_valid_o, output, 1, pc_o is a valid fetch this cycle.
- flush_o, output, 1, kill IF/ID contents (redirect applied this cycle).
- misalign_o, output, 1, misaligned target seen; present only when the Configuration macro is defined.

## Operation
The controller has four states: BOOT, RUN, HOLD and PEND.

- BOOT: entered on reset.
  - pc_o = RESET_PC, fetch_valid_o = 0.
  - Goes to RUN unconditionally on the next cycle.
- RUN: fetch_valid_o = 1.
  - If redir_valid_i = 1: pc_sel_o = 1 and flush_o = 1, with tgt_o = redir_target_i. This takes priority over stall_i, because the branch resolves in EX independently of the IF hold.
  - Else if stall_i = 1: go to HOLD, pc_o holds.
  - Else: pc_o <= pc_next_i, which is npc_o.
- HOLD: pc_o holds, fetch_valid_o = 1 (same PC re-presented).
  - If redir_valid_i = 1 while stall_i = 1: latch redir_target_i into pend_tgt and go to PEND. flush_o = 1 in that cycle.
  - If redir_valid_i = 1 while stall_i = 0: apply the redirect as in RUN, then go to RUN.
  - If stall_i = 0 with no redirect: advance pc_o to npc_o and go to RUN.
- PEND: fetch_valid_o = 0, tgt_o = pend_tgt.
  - Further redir_valid_i pulses are ignored, because the older redirect wins.
  - When stall_i = 0: pc_sel_o = 1, pc_o <= pc_next_i (= pend_tgt), go to RUN.
- Outputs npc_o, tgt_o, pc_sel_o and flush_o are combinational from state and inputs. pc_o and fetch_valid_o are registered.
- Arithmetic: npc_o = pc_o + 4, modulo 2^PC_W. 32'hFFFF_FFFC wraps to 0 with no flag.
- When no redirect is applied, tgt_o = redir_target_i and pc_sel_o = 0.

## Timing
Reset values:
- pc_o = RESET_PC, fetch_valid_o = 0, state = BOOT.
- pend_tgt = 0, misalign_o = 0.
- Combinational outputs evaluate from these: pc_sel_o = 0, flush_o = 0, npc_o = RESET_PC + 4.

Latency and boundary behaviour:
- A redirect in cycle N with no stall gives pc_o = target in N+1 and flush_o high in N only.
- A redirect during a stall is applied in the first cycle stall_i is low. pc_o = target one cycle after that.
- stall_i held for k cycles holds pc_o for exactly k cycles.
- rst_n low mid-operation overrides everything at the next edge, including any PEND state. The buffered target is discarded.
- pc_next_i is sampled only on the advance edge and must settle within the cycle; the mux is combinational, so this adds zero cycles.

## Configuration
Macro: IF_PC_ALIGN_CHECK_EN.

- Defined:
  - Any applied or latched target with bits [1:0] != 0 forces tgt_o[1:0] = 2'b00.
  - misalign_o pulses high for one cycle, registered, in the cycle after the redirect.
- Undefined:
  - The misalign_o port is absent.
  - The target passes through unmodified.

## Test plan
- Reset release, no stall for 4 cycles -> fetch_valid_o 0 then 1; pc_o = 0, 0, 4, 8, 12.
- At pc_o = 8, redir_valid_i = 1 with target 32'h0000_0100 -> flush_o high for that cycle only, pc_sel_o = 1; next cycle pc_o = 0x100, then 0x104.
- stall_i high for 3 cycles at pc_o = 0x10 -> pc_o stays 0x10 for 3 cycles, then goes to 0x14.
- With stall_i high, redirect to 0x200, then a second redirect to 0x300, then stall released -> pc_o = 0x200; 0x300 is ignored; fetch_valid_o = 0 while in PEND.
- RESET_PC = 32'hFFFF_FFF8, no stall -> pc_o = FFFF_FFF8, FFFF_FFFC, 0000_0000.
- With IF_PC_ALIGN_CHECK_EN defined, redirect to 0x103 -> pc_o = 0x100 and misalign_o pulses for one cycle. Undefined: pc_o = 0x103.
- rst_n low while in PEND -> next cycle pc_o = RESET_PC, state BOOT, pending target dropped.
